ahb_master_req_ctrl: RTL and testbench
======================================

AHB_MASTER_REQ_CTRL -- requirements
Module: ahb_master_req_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-002 hclk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 hreset_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  SHALL mark a local burst command present.
REQ-005 cmd_ready  output  1  SHALL indicate the block accepts a command this cycle.
REQ-006 cmd_addr  input  ADDR_W  SHALL be the burst start address.
REQ-007 cmd_burst  input  hburst_type  SHALL be the burst type (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16).
REQ-008 cmd_len  input  4  SHALL be the beat count minus 1 for INCR only; ignored otherwise.
REQ-009 cmd_write, cmd_size  input  1, 3  SHALL be the direction and transfer size.
REQ-010 hreq  output  1  SHALL be the request to the slave-side arbiter.
REQ-011 hgrant  input  1  SHALL be the arbiter grant, already gated low while the slave is waiting.
REQ-012 hwait  input  1  SHALL be the slave wait indication, active-high.
REQ-013 haddr, htrans, hburst, hwrite, hsize  output  ADDR_W, 2, hburst_type, 1, 3  SHALL be the AHB address-phase signals.
REQ-014 beat_done  output  1  SHALL pulse for each accepted beat; last_done  output  1  SHALL pulse on the final beat.

Function
REQ-015 FSM states SHALL be IDLE, REQ and XFER.
REQ-016 IDLE: cmd_ready=1, hreq=0, htrans=IDLE(00); cmd_valid=1 latches the command and moves to REQ next cycle.
REQ-017 REQ: hreq=1, htrans=IDLE; hgrant=1 moves to XFER next cycle.
REQ-018 XFER: hreq=1; htrans=NONSEQ(10) on the first beat after entry, SEQ(11) thereafter.
REQ-019 A beat SHALL be accepted only when hgrant=1 and hwait=0; haddr/htrans SHALL hold otherwise.
REQ-020 Beat total SHALL be 1 for SINGLE, cmd_len+1 for INCR, and 4/8/16 for the fixed bursts; the 5-bit counter SHALL NOT wrap.
REQ-021 Per accepted beat, the address SHALL advance by (1<<hsize) bytes, modulo 2^ADDR_W.
REQ-022 On acceptance of the last beat: last_done=1, htrans=IDLE next cycle, hreq=0 next cycle, return to IDLE.
REQ-023 Grant loss in XFER (hgrant=0, hwait=0, beats remaining) SHALL return to REQ, holding the current address and remaining count; on re-grant the first beat SHALL be NONSEQ.
REQ-024 hwait=1 SHALL freeze the counter, address and state, regardless of hgrant.
REQ-025 cmd_ready SHALL be 0 outside IDLE; cmd_valid there SHALL be ignored.
REQ-026 last_done and beat_done SHALL assert in the same cycle on the final beat.

Reset
REQ-027 Reset SHALL force state IDLE, hreq=0, htrans=00, haddr=0, hburst=SINGLE, hwrite=0, hsize=0, beat_done=0, last_done=0 and count=0.
REQ-028 Reset mid-burst SHALL abort the burst with no resume; cmd_ready=1 on the first cycle after release.

Configuration
REQ-029 Macro AHB_MASTER_WRAP_EN defined: WRAP4/8/16 addresses SHALL wrap within a (beats*(1<<hsize))-byte aligned block.
REQ-030 Macro AHB_MASTER_WRAP_EN undefined: WRAP bursts SHALL be issued with hburst unchanged but with linear (INCR) addressing.

Verification
REQ-031 SINGLE write @0x100, size=2, grant on 2nd cycle of REQ -> one NONSEQ at 0x100; beat_done=last_done=1; hreq low the next cycle.
REQ-032 INCR4 @0x200, size=2, no waits -> haddr 0x200/204/208/20C; htrans NONSEQ, SEQ, SEQ, SEQ.
REQ-033 INCR8 with hwait=1 for 3 cycles on beat 3 -> haddr and count held 3 cycles; 8 beat_done pulses total.
REQ-034 WRAP4 @0x38, size=2, macro defined -> 0x38/3C/30/34; macro undefined -> 0x38/3C/40/44.
REQ-035 INCR16, hgrant drops after beat 5 then returns 4 cycles later -> resumes NONSEQ at start+0x14 (size=2); 16 beats total.
REQ-036 Reset asserted during beat 2 of INCR4 -> all outputs reset values the same cycle; cmd_ready=1 after release.

Source files
------------

// File: rtl/ahb_master_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_req_ctrl
//  Description : AHB master request/transfer controller. Accepts a local
//                burst command, requests the bus from the arbiter, and issues
//                the address phase of each beat (NONSEQ/SEQ) until the burst
//                completes. Grant loss mid-burst re-arbitrates and resumes
//                with a NONSEQ beat at the held address.
//  Options     : `AHB_MASTER_WRAP_EN -- when defined, WRAP4/8/16 bursts wrap
//                at the (beats << hsize)-byte boundary; otherwise WRAP bursts
//                use linear addressing with hburst still reporting WRAPx.
//  Ports       : hclk, hreset_n (async, active-low)
//                cmd_valid/cmd_ready/cmd_addr/cmd_burst/cmd_len/cmd_write/
//                cmd_size                         - local command interface
//                hreq/hgrant/hwait                - arbiter and slave handshake
//                haddr/htrans/hburst/hwrite/hsize - AHB address phase
//                beat_done/last_done              - per-beat and final-beat pulses
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_master_req_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_burst,
    input  logic [3:0]        cmd_len,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_size,
    output logic              hreq,
    input  logic              hgrant,
    input  logic              hwait,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic [2:0]        hburst,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic              beat_done,
    output logic              last_done
);

    // AHB burst encodings
    localparam logic [2:0] C_SINGLE = 3'b000;
    localparam logic [2:0] C_INCR   = 3'b001;
    localparam logic [2:0] C_WRAP4  = 3'b010;
    localparam logic [2:0] C_INCR4  = 3'b011;
    localparam logic [2:0] C_WRAP8  = 3'b100;
    localparam logic [2:0] C_INCR8  = 3'b101;
    localparam logic [2:0] C_WRAP16 = 3'b110;
    localparam logic [2:0] C_INCR16 = 3'b111;

    // AHB transfer types
    localparam logic [1:0] C_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_count;     // beats remaining in the burst
    logic              r_first;     // next beat is the first of a grant tenure
    logic [ADDR_W-1:0] r_haddr;
    logic [2:0]        r_hburst;
    logic              r_hwrite;
    logic [2:0]        r_hsize;

    logic [4:0]        w_cmd_beats;
    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_addr_lin;
    logic [ADDR_W-1:0] w_addr_nxt;

    // Total beats for the incoming command
    always_comb begin
        w_cmd_beats = 5'd1;
        case (cmd_burst)
            C_SINGLE:          w_cmd_beats = 5'd1;
            C_INCR:            w_cmd_beats = {1'b0, cmd_len} + 5'd1;
            C_WRAP4, C_INCR4:  w_cmd_beats = 5'd4;
            C_WRAP8, C_INCR8:  w_cmd_beats = 5'd8;
            C_WRAP16, C_INCR16: w_cmd_beats = 5'd16;
            default:           w_cmd_beats = 5'd1;
        endcase
    end

    assign w_accept   = (r_state == S_XFER) && hgrant && !hwait;
    assign w_last     = w_accept && (r_count == 5'd1);
    assign w_incr     = ADDR_W'(1) << r_hsize;
    assign w_addr_lin = r_haddr + w_incr;

`ifdef AHB_MASTER_WRAP_EN
    logic [4:0]        w_wrap_beats;
    logic [ADDR_W-1:0] w_wrap_mask;

    always_comb begin
        w_wrap_beats = 5'd0;
        case (r_hburst)
            C_WRAP4:  w_wrap_beats = 5'd4;
            C_WRAP8:  w_wrap_beats = 5'd8;
            C_WRAP16: w_wrap_beats = 5'd16;
            default:  w_wrap_beats = 5'd0;
        endcase
    end

    // Offset bits inside the wrap block come from the incremented address,
    // the block base bits stay put.
    assign w_wrap_mask = (ADDR_W'(w_wrap_beats) << r_hsize) - ADDR_W'(1);
    assign w_addr_nxt  = (w_wrap_beats != 5'd0) ?
                         ((r_haddr & ~w_wrap_mask) | (w_addr_lin & w_wrap_mask)) :
                         w_addr_lin;
`else
    assign w_addr_nxt  = w_addr_lin;
`endif

    // Next-state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        hreq        = 1'b0;
        htrans      = C_HTRANS_IDLE;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                hreq = 1'b1;
                if (hgrant) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                hreq   = 1'b1;
                htrans = r_first ? C_HTRANS_NONSEQ : C_HTRANS_SEQ;
                // hwait freezes everything; otherwise finish or re-arbitrate
                if (!hwait) begin
                    if (hgrant) begin
                        if (w_last) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign beat_done = w_accept;
    assign last_done = w_last;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_first  <= 1'b0;
            r_haddr  <= '0;
            r_hburst <= C_SINGLE;
            r_hwrite <= 1'b0;
            r_hsize  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && cmd_valid) begin
                r_haddr  <= cmd_addr;
                r_hburst <= cmd_burst;
                r_hwrite <= cmd_write;
                r_hsize  <= cmd_size;
                r_count  <= w_cmd_beats;
            end else if (w_accept) begin
                r_haddr <= w_addr_nxt;
                if (r_count != 5'd0) begin
                    r_count <= r_count - 5'd1;
                end
            end
            // Every (re)entry into XFER starts with a NONSEQ beat
            if ((r_state == S_REQ) && hgrant) begin
                r_first <= 1'b1;
            end else if (w_accept) begin
                r_first <= 1'b0;
            end
        end
    end

    assign haddr  = r_haddr;
    assign hburst = r_hburst;
    assign hwrite = r_hwrite;
    assign hsize  = r_hsize;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_master_req_ctrl
//  Description : Self-checking bench for ahb_master_req_ctrl. A vector table
//                of bursts with fixed expected addresses, scripted wait /
//                grant-loss / reset sequences and random bursts, all checked
//                against a burst-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_master_req_ctrl;

    logic        hclk = 1'b0;
    logic        hreset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [2:0]  cmd_burst = '0;
    logic [3:0]  cmd_len = '0;
    logic        cmd_write = 1'b0;
    logic [2:0]  cmd_size = '0;
    logic        hreq;
    logic        hgrant = 1'b0;
    logic        hwait = 1'b0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        beat_done;
    logic        last_done;

    int total = 0;
    int bad   = 0;

    ahb_master_req_ctrl #(.ADDR_W(32)) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_len   (cmd_len),
        .cmd_write (cmd_write),
        .cmd_size  (cmd_size),
        .hreq      (hreq),
        .hgrant    (hgrant),
        .hwait     (hwait),
        .haddr     (haddr),
        .htrans    (htrans),
        .hburst    (hburst),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .beat_done (beat_done),
        .last_done (last_done)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beats per burst from the burst type
    function automatic int nbeats(input logic [2:0] b, input logic [3:0] l);
        case (b)
            3'd0:       return 1;
            3'd1:       return int'(l) + 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    // Address of beat k, computed directly from the start address
    function automatic logic [31:0] exp_addr(input logic [31:0] start, input logic [2:0] b,
                                             input logic [2:0] s, input int k);
        logic [31:0] inc;
        inc = 32'd1 << s;
`ifdef AHB_MASTER_WRAP_EN
        if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
            logic [31:0] blk;
            logic [31:0] base;
            blk  = 32'(nbeats(b, 4'd0)) * inc;
            base = start - (start % blk);
            return base + (((start - base) + 32'(k) * inc) % blk);
        end
`endif
        return start + 32'(k) * inc;
    endfunction

    // mode 0: full grant, no waits       mode 1: random grant/wait
    // mode 2: grant from 2nd REQ cycle   mode 3: 3 wait cycles on beat 3
    // mode 4: grant lost 4 cycles after beat 5
    // mode 5: reset asserted during beat 2
    task automatic run_burst(input logic [2:0] b, input logic [31:0] a, input logic [2:0] s,
                             input logic [3:0] l, input logic w, input int mode,
                             output int beats_seen, output logic [3:0][31:0] obs);
        int   n;
        int   k;
        int   cyc;
        int   waited;
        int   dropped;
        int   pulses;
        bit   in_xfer;
        bit   first;
        bit   done;
        logic g;
        logic wt;
        logic acc;
        n = nbeats(b, l);
        k = 0; cyc = 0; waited = 0; dropped = 0; pulses = 0;
        in_xfer = 0; first = 0; done = 0;
        obs = '0;

        @(negedge hclk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_burst = b; cmd_len = l;
        cmd_write = w; cmd_size = s; hgrant = 1'b0; hwait = 1'b0;
        #1;
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("idle_hreq", 32'(hreq), 32'd0);
        chk("idle_htrans", 32'(htrans), 32'd0);

        while (!done && cyc < 600) begin
            @(negedge hclk);
            cyc++;
            // Commands offered while busy must be ignored
            cmd_valid = 1'($urandom % 2); cmd_addr = $urandom; cmd_burst = 3'($urandom);
            cmd_len = 4'($urandom); cmd_write = 1'($urandom); cmd_size = 3'($urandom);
            g = 1'b1; wt = 1'b0;
            case (mode)
                1: begin
                    wt = ($urandom % 4) == 0;
                    g  = ($urandom % 4) != 0;
                end
                2: g = (cyc >= 2);
                3: if (in_xfer && k == 2 && waited < 3) begin wt = 1'b1; waited++; end
                4: if (k == 5 && dropped < 4) begin g = 1'b0; dropped++; end
                default: ;
            endcase
            hgrant = g; hwait = wt;

            if (mode == 5 && in_xfer && k == 1) begin
                cmd_valid = 1'b0;
                hreset_n = 1'b0;
                #1;
                chk("rst_hreq", 32'(hreq), 32'd0);
                chk("rst_htrans", 32'(htrans), 32'd0);
                chk("rst_haddr", haddr, 32'd0);
                chk("rst_hburst", 32'(hburst), 32'd0);
                chk("rst_hwrite", 32'(hwrite), 32'd0);
                chk("rst_hsize", 32'(hsize), 32'd0);
                chk("rst_beat_done", 32'(beat_done), 32'd0);
                chk("rst_last_done", 32'(last_done), 32'd0);
                @(negedge hclk);
                hreset_n = 1'b1;
                #1;
                chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
                @(negedge hclk);
                #1;
                chk("rel_no_resume_htrans", 32'(htrans), 32'd0);
                chk("rel_no_resume_beat", 32'(beat_done), 32'd0);
                chk("rel_no_resume_hreq", 32'(hreq), 32'd0);
                beats_seen = k;
                return;
            end

            #1;
            acc = in_xfer && g && !wt;
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("busy_hreq", 32'(hreq), 32'd1);
            chk("htrans", 32'(htrans), in_xfer ? (first ? 32'd2 : 32'd3) : 32'd0);
            chk("beat_done", 32'(beat_done), 32'(acc));
            chk("last_done", 32'(last_done), 32'(acc && (k == n - 1)));
            if (in_xfer) begin
                chk("haddr", haddr, exp_addr(a, b, s, k));
                chk("hburst", 32'(hburst), 32'(b));
                chk("hsize", 32'(hsize), 32'(s));
                chk("hwrite", 32'(hwrite), 32'(w));
            end
            if (beat_done) pulses++;
            if (acc) begin
                if (k < 4) obs[k] = haddr;
                k++;
                first = 0;
                if (k == n) done = 1;
            end
            if (in_xfer) begin
                if (done || (!g && !wt)) in_xfer = 0;
            end else if (g) begin
                in_xfer = 1;
                first   = 1;
            end
        end
        if (!done) chk("burst_timeout", 32'd0, 32'd1);
        chk("beat_pulses", 32'(pulses), 32'(n));

        @(negedge hclk);
        cmd_valid = 1'b0; hgrant = 1'b0; hwait = 1'b0;
        #1;
        chk("end_hreq", 32'(hreq), 32'd0);
        chk("end_htrans", 32'(htrans), 32'd0);
        chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
        beats_seen = k;
    endtask

    typedef struct {
        logic [2:0]  b;
        logic [31:0] a;
        logic [2:0]  s;
        logic [3:0]  l;
        logic        w;
        int          mode;
        int          nb;
        logic [31:0] e0, e1, e2, e3;
    } vec_t;

    vec_t tbl[9];

    initial begin : main
        int               beats;
        logic [3:0][31:0] obs;
        logic [31:0]      exp4 [4];
        logic [2:0]       rb;
        logic [2:0]       rs;
        logic [31:0]      ra;

        tbl[0] = '{3'd0, 32'h100, 3'd2, 4'd0, 1'b1, 2, 1, 32'h100, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{3'd3, 32'h200, 3'd2, 4'd0, 1'b0, 0, 4, 32'h200, 32'h204, 32'h208, 32'h20C};
`ifdef AHB_MASTER_WRAP_EN
        tbl[2] = '{3'd2, 32'h38, 3'd2, 4'd0, 1'b1, 0, 4, 32'h38, 32'h3C, 32'h30, 32'h34};
        tbl[6] = '{3'd4, 32'h1D, 3'd0, 4'd0, 1'b1, 1, 8, 32'h1D, 32'h1E, 32'h1F, 32'h18};
        tbl[7] = '{3'd6, 32'h78, 3'd3, 4'd0, 1'b0, 0, 16, 32'h78, 32'h0, 32'h8, 32'h10};
`else
        tbl[2] = '{3'd2, 32'h38, 3'd2, 4'd0, 1'b1, 0, 4, 32'h38, 32'h3C, 32'h40, 32'h44};
        tbl[6] = '{3'd4, 32'h1D, 3'd0, 4'd0, 1'b1, 1, 8, 32'h1D, 32'h1E, 32'h1F, 32'h20};
        tbl[7] = '{3'd6, 32'h78, 3'd3, 4'd0, 1'b0, 0, 16, 32'h78, 32'h80, 32'h88, 32'h90};
`endif
        tbl[3] = '{3'd5, 32'h400, 3'd2, 4'd0, 1'b0, 3, 8, 32'h400, 32'h404, 32'h408, 32'h40C};
        tbl[4] = '{3'd7, 32'h1000, 3'd2, 4'd0, 1'b1, 4, 16, 32'h1000, 32'h1004, 32'h1008, 32'h100C};
        tbl[5] = '{3'd1, 32'hFFFF_FFFE, 3'd0, 4'd2, 1'b0, 0, 3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h0};
        tbl[8] = '{3'd1, 32'h20, 3'd1, 4'd15, 1'b1, 1, 16, 32'h20, 32'h22, 32'h24, 32'h26};

        // Reset values while held in reset
        #2;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_hreq", 32'(hreq), 32'd0);
        chk("reset_htrans", 32'(htrans), 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_hburst", 32'(hburst), 32'd0);
        chk("reset_beat_done", 32'(beat_done), 32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1'b1;

        foreach (tbl[i]) begin
            run_burst(tbl[i].b, tbl[i].a, tbl[i].s, tbl[i].l, tbl[i].w, tbl[i].mode, beats, obs);
            exp4[0] = tbl[i].e0; exp4[1] = tbl[i].e1; exp4[2] = tbl[i].e2; exp4[3] = tbl[i].e3;
            chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(tbl[i].nb));
            for (int j = 0; j < 4 && j < tbl[i].nb; j++) begin
                chk($sformatf("vec%0d_addr%0d", i, j), obs[j], exp4[j]);
            end
        end

        // Reset during beat 2 of INCR4
        run_burst(3'd3, 32'h300, 3'd2, 4'd0, 1'b1, 5, beats, obs);
        chk("abort_beats", 32'(beats), 32'd1);

        // Random bursts under random grant/wait
        for (int r = 0; r < 30; r++) begin
            rb = 3'($urandom);
            rs = 3'($urandom_range(0, 3));
            ra = $urandom & ~((32'd1 << rs) - 32'd1);
            run_burst(rb, ra, rs, 4'($urandom), 1'($urandom), 1, beats, obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
